// File: rtl/wb_uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the Wishbone UART.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_RX_FERR  = 3;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/if_wb.sv
// Zero-wait-state Wishbone bus as driven by the J1-to-Wishbone bridge (no ack).
interface if_wb;
  logic [15:0] adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        stb;
  logic        cyc;
  logic        we;

  modport slave  (input adr, dat_m, stb, cyc, we, output dat_s);
  modport master (output adr, dat_m, stb, cyc, we, input dat_s);
endinterface

// File: rtl/wb_uart_rx.sv
// 8N1 receiver: rxd synchronizer, mid-bit sampling FSM and the RX holding register with its flags.
module wb_uart_rx
  import wb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic [15:0] div,
  input  logic        rd_clr,
  input  logic        w1c_ovr,
  input  logic        w1c_ferr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_ovr,
  output logic        rx_ferr
);

  uart_state_t state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic        brk_q, brk_d;
  logic        tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    brk_d   = brk_q;
    // Clears first so that a same-cycle flag set below wins.
    valid_d = valid_q & ~rd_clr;
    ovr_d   = ovr_q & ~w1c_ovr;
    ferr_d  = ferr_q & ~w1c_ferr;
    unique case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = (div >> 1) - 16'd1;
        end
      end
      START: begin
        if (tick) begin
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = div - 16'd1;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_d  = {sync2_q, sh_q[7:1]};
          cnt_d = div - 16'd1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line returns high (break or bad stop).
        if (brk_q) begin
          if (sync2_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (tick) begin
          if (sync2_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            if (valid_q && !rd_clr) ovr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ovr   = ovr_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/wb_uart.sv
// Wishbone UART slave: 4-register window decode, combinational read mux, DIVISOR and 8N1 TX FSM.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hF000,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic clk,
  input  logic reset,
  if_wb.slave  wb,
  input  logic rxd,
  output logic txd
);

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;
  logic        sel, wr, rd, tx_busy, tx_tick;
  logic [1:0]  idx;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ovr, rx_ferr;
  logic        unused_adr;

  assign sel        = wb.stb & wb.cyc & (wb.adr[15:3] == BASE[15:3]);
  assign idx        = wb.adr[2:1];
  assign wr         = sel & wb.we;
  assign rd         = sel & ~wb.we;
  assign unused_adr = wb.adr[0];
  assign tx_busy    = (tx_state_q != IDLE);
  assign tx_tick    = (tx_cnt_q == 16'd0);

  wb_uart_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .div      (div_q),
    .rd_clr   (rd && (idx == REG_DATA)),
    .w1c_ovr  (wr && (idx == REG_STATUS) && wb.dat_m[ST_RX_OVR]),
    .w1c_ferr (wr && (idx == REG_STATUS) && wb.dat_m[ST_RX_FERR]),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ovr   (rx_ovr),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      div_q      <= DIV_RESET;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      div_q      <= div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr && (idx == REG_DIV)) div_d = (wb.dat_m < DIV_MIN) ? DIV_MIN : wb.dat_m;
  end

  // Counter reloads from div_q at each bit boundary, so DIVISOR changes apply from the next bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - 16'd1;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (wr && (idx == REG_DATA)) begin
          tx_state_d = START;
          tx_sh_d    = wb.dat_m[7:0];
          tx_cnt_d   = div_q - 16'd1;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_d = DATA;
          tx_cnt_d   = div_q - 16'd1;
          tx_idx_d   = 3'd0;
          txd_d      = tx_sh_q[0];
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_cnt_d = div_q - 16'd1;
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
            txd_d   = tx_sh_q[1];
          end
        end
      end
      STOP: begin
        if (tx_tick) tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    wb.dat_s = 16'h0000;
    if (sel) begin
      unique case (idx)
        REG_DATA:   wb.dat_s = {8'h00, rx_data};
        REG_STATUS: wb.dat_s = {12'h000, rx_ferr, rx_ovr, tx_busy, rx_valid};
        REG_DIV:    wb.dat_s = div_q;
        default:    wb.dat_s = 16'h0000;
      endcase
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart: TX framing, busy-write drop, RX data/flags, glitch, clamp, decode, reset.
module tb_wb_uart;

  localparam logic [15:0] BASE  = 16'hF000;
  localparam logic [15:0] A_DAT = 16'hF000;
  localparam logic [15:0] A_STS = 16'hF002;
  localparam logic [15:0] A_DIV = 16'hF004;
  localparam logic [15:0] A_R3  = 16'hF006;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic txd;
  int   n_cmp = 0;
  int   n_bad = 0;

  if_wb wb_if ();

  wb_uart #(.BASE(BASE), .DIV_RESET(16'd434)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    wb_if.adr = 16'h0000; wb_if.dat_m = 16'h0000;
    wb_if.we = 1'b0; wb_if.stb = 1'b0; wb_if.cyc = 1'b0;
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wb_if.adr = a; wb_if.dat_m = d; wb_if.we = 1'b1; wb_if.stb = 1'b1; wb_if.cyc = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    wb_if.adr = a; wb_if.we = 1'b0; wb_if.stb = 1'b1; wb_if.cyc = 1'b1;
    #1 d = wb_if.dat_s;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    @(negedge clk);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (div) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    logic [9:0]  frame;
    int          busy_n;
    int          low_n;

    reset = 1'b1;
    rxd   = 1'b1;
    bus_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_txd", txd, 1);
    wb_read(A_STS, rd); chk("rst_status", rd, 16'h0000);
    wb_read(A_DIV, rd); chk("rst_div", rd, 16'd434);
    wb_read(A_DAT, rd); chk("rst_data", rd, 16'h0000);

    // TX frame of A5 at DIVISOR=4, with a DATA write of 55 dropped mid-frame.
    wb_write(A_DIV, 16'd4);
    wb_write(A_DAT, 16'h00A5);
    frame  = {1'b1, 8'hA5, 1'b0};
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        wb_if.adr = A_DAT; wb_if.dat_m = 16'h0055; wb_if.we = 1'b1;
      end else begin
        wb_if.adr = A_STS; wb_if.we = 1'b0;
      end
      wb_if.stb = 1'b1; wb_if.cyc = 1'b1;
      #1;
      if (k % 4 == 2) chk($sformatf("tx_bit%0d", k / 4), txd, frame[k / 4]);
      if (k != 10 && wb_if.dat_s[1]) busy_n++;
      @(negedge clk);
    end
    bus_idle();
    chk("tx_busy_cycles", busy_n, 39);
    wb_read(A_STS, rd); chk("tx_busy_done", rd, 16'h0000);
    low_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!txd) low_n++;
    end
    chk("tx_no_second_frame", low_n, 0);

    // RX good frame at DIVISOR=8.
    wb_write(A_DIV, 16'd8);
    send_frame(8'h3C, 1'b1, 8);
    wb_read(A_STS, rd); chk("rx_status", rd, 16'h0001);
    wb_read(A_DAT, rd); chk("rx_data", rd, 16'h003C);
    wb_read(A_STS, rd); chk("rx_status_clr", rd, 16'h0000);

    // Overrun, then W1C.
    send_frame(8'h11, 1'b1, 8);
    send_frame(8'h22, 1'b1, 8);
    wb_read(A_STS, rd); chk("ovr_status", rd, 16'h0005);
    wb_read(A_DAT, rd); chk("ovr_data", rd, 16'h0022);
    wb_write(A_STS, 16'h0004);
    wb_read(A_STS, rd); chk("ovr_w1c", rd, 16'h0000);

    // Framing error leaves rx_valid and rx_data alone.
    send_frame(8'h77, 1'b1, 8);
    send_frame(8'h99, 1'b0, 8);
    wb_read(A_STS, rd); chk("ferr_status", rd, 16'h0009);
    wb_read(A_DAT, rd); chk("ferr_data", rd, 16'h0077);
    wb_write(A_STS, 16'h0008);
    wb_read(A_STS, rd); chk("ferr_w1c", rd, 16'h0000);

    // Glitch rejection and DIVISOR clamp.
    @(negedge clk); rxd = 1'b0;
    repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (20) @(negedge clk);
    wb_read(A_STS, rd); chk("glitch_status", rd, 16'h0000);
    wb_write(A_DIV, 16'd1);
    wb_read(A_DIV, rd); chk("div_clamp", rd, 16'd4);
    wb_write(A_R3, 16'hFFFF);
    wb_read(A_R3, rd); chk("reg3_zero", rd, 16'h0000);

    // Accesses just outside the window.
    wb_write(BASE + 16'h0008, 16'h0012);
    repeat (3) @(negedge clk);
    chk("oow_txd_idle", txd, 1);
    wb_read(BASE + 16'h000A, rd); chk("oow_read", rd, 16'h0000);
    wb_write(BASE + 16'h000C, 16'h0020);
    wb_read(A_DIV, rd); chk("oow_div_kept", rd, 16'd4);
    wb_read(A_STS, rd); chk("oow_no_busy", rd, 16'h0000);

    // Reset in the middle of a frame.
    wb_write(A_DAT, 16'h0000);
    repeat (5) @(negedge clk);
    chk("mid_tx_txd", txd, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_txd", txd, 1);
    @(negedge clk);
    reset = 1'b0;
    wb_read(A_DIV, rd); chk("reset_div", rd, 16'd434);
    wb_read(A_STS, rd); chk("reset_status", rd, 16'h0000);
    wb_read(A_DAT, rd); chk("reset_data", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
